cpu_fetch_unit: RTL and testbench

Instruction-fetch initiator for the 8-bit-address / 12-bit-word combinational program ROM. It owns the program counter and drives the ROM address. It captures the returned word into an instruction register and hands it to the decode stage over a valid/ready handshake. It supports branch redirect, external halt/start and self-halt on a HALT opcode.

---
 rtl/cpu_pkg.sv | 9 +
 rtl/cpu_fetch_unit_if.sv | 12 +
 rtl/cpu_pc_reg.sv | 19 +
 rtl/cpu_fetch_unit.sv | 59 +++++
 tb/tb_cpu_fetch_unit.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcode field slice and fetch-state encoding for the CPU front end.
package cpu_pkg;
    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 12;
    localparam int OPC_MSB = 11;
    localparam int OPC_LSB = 8;
    localparam logic [3:0] HALT_OPCODE = 4'hF;
    typedef enum logic [1:0] {FS_IDLE, FS_FETCH, FS_HALTED} fetch_state_t;
endpackage

// File: rtl/cpu_fetch_unit_if.sv
// cpu_fetch_unit_if: program ROM port plus the valid/ready instruction hand-off to decode.
interface cpu_fetch_unit_if;
    import cpu_pkg::*;
    logic [ADDR_WIDTH-1:0] rom_address;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    modport master (output rom_address, instr_valid, instr, instr_pc, input rom_data, instr_ready);
    modport slave (input rom_address, instr_valid, instr, instr_pc, output rom_data, instr_ready);
endinterface

// File: rtl/cpu_pc_reg.sv
// cpu_pc_reg: program counter with load (priority), wrapping increment and hold.
module cpu_pc_reg
    import cpu_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  inc,
    input  logic [ADDR_WIDTH-1:0] target,
    output logic [ADDR_WIDTH-1:0] pc
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc <= RESET_PC;
        else if (load) pc <= target;
        else if (inc) pc <= pc + 1'b1;
    end
endmodule

// File: rtl/cpu_fetch_unit.sv
// cpu_fetch_unit: owns the PC, fetches from the combinational ROM into an instruction register
// and presents it to decode; supports redirect, external halt/start and self-halt on HALT opcode.
module cpu_fetch_unit #(
    parameter logic [cpu_pkg::ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter logic [3:0] HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           halt,
    input  logic                           redirect,
    input  logic [cpu_pkg::ADDR_WIDTH-1:0] redirect_target,
    output logic                           running,
    cpu_fetch_unit_if.master               bus
);
    import cpu_pkg::*;
    fetch_state_t state, state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic fetch;
    cpu_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk(clk),
        .rst(rst),
        .load(redirect),
        .inc(fetch),
        .target(redirect_target),
        .pc(pc)
    );
    assign bus.rom_address = pc;
    assign fetch = state == FS_FETCH && (!bus.instr_valid || bus.instr_ready) && !redirect && !halt;
    // Redirect leaves state alone; halt beats start; self-halt happens on the edge that loads the HALT word.
    always_comb begin
        state_next = redirect ? state
                   : halt ? (state == FS_FETCH ? FS_HALTED : state)
                   : (start && state != FS_FETCH) ? FS_FETCH
                   : (fetch && bus.rom_data[OPC_MSB:OPC_LSB] == HALT_OPCODE) ? FS_HALTED
                   : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FS_IDLE;
            running <= 1'b0;
            bus.instr_valid <= 1'b0;
            bus.instr <= '0;
            bus.instr_pc <= '0;
        end else begin
            state <= state_next;
            running <= state_next == FS_FETCH;
            if (redirect) begin
                bus.instr_valid <= 1'b0;
            end else if (fetch) begin
                bus.instr_valid <= 1'b1;
                bus.instr <= bus.rom_data;
                bus.instr_pc <= pc;
            end else if (bus.instr_ready) begin
                bus.instr_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cpu_fetch_unit.sv
// tb_cpu_fetch_unit: directed checks of fetch, stall, redirect, wrap, halts and async reset.
module tb_cpu_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic halt = 1'b0;
    logic redirect = 1'b0;
    logic [7:0] redirect_target = '0;
    logic running;
    int checks = 0;
    int errors = 0;
    cpu_fetch_unit_if bus ();
    cpu_fetch_unit dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .halt(halt),
        .redirect(redirect),
        .redirect_target(redirect_target),
        .running(running),
        .bus(bus)
    );
    always #5 clk = ~clk;
    function automatic logic [11:0] rom(input logic [7:0] a);
        case (a)
            8'h00: rom = 12'h000;
            8'h01: rom = 12'h121;
            8'h02: rom = 12'h100;
            8'h03: rom = 12'h116;
            8'h04: rom = 12'hF00;
            default: rom = {4'h1, a};
        endcase
    endfunction
    assign bus.rom_data = rom(bus.rom_address);
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_instr(input string tag, input logic [11:0] i, input logic [7:0] p);
        chk({tag, " valid"}, 32'(bus.instr_valid), 32'd1);
        chk({tag, " instr"}, 32'(bus.instr), 32'(i));
        chk({tag, " pc"}, 32'(bus.instr_pc), 32'(p));
    endtask
    initial begin
        bus.instr_ready = 1'b1;
        #12;
        chk("reset valid", 32'(bus.instr_valid), 32'd0);
        chk("reset addr", 32'(bus.rom_address), 32'd0);
        chk("reset running", 32'(running), 32'd0);
        chk("reset instr", 32'(bus.instr), 32'd0);
        chk("reset instr_pc", 32'(bus.instr_pc), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle valid", 32'(bus.instr_valid), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start running", 32'(running), 32'd1);
        chk("start valid", 32'(bus.instr_valid), 32'd0);
        tick();
        chk_instr("f0", 12'h000, 8'h00);
        tick();
        chk_instr("f1", 12'h121, 8'h01);
        chk("f1 addr", 32'(bus.rom_address), 32'h02);
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_instr("stall", 12'h121, 8'h01);
            chk("stall addr", 32'(bus.rom_address), 32'h02);
        end
        bus.instr_ready = 1'b1;
        tick();
        chk_instr("f2", 12'h100, 8'h02);
        tick();
        chk_instr("f3", 12'h116, 8'h03);
        tick();
        chk_instr("selfhalt", 12'hF00, 8'h04);
        chk("selfhalt running", 32'(running), 32'd0);
        chk("selfhalt addr", 32'(bus.rom_address), 32'h05);
        tick();
        chk("halted drain", 32'(bus.instr_valid), 32'd0);
        chk("halted addr", 32'(bus.rom_address), 32'h05);
        tick();
        chk("halted idle", 32'(bus.instr_valid), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("resume running", 32'(running), 32'd1);
        tick();
        chk_instr("f5", 12'h105, 8'h05);
        bus.instr_ready = 1'b0;
        tick();
        chk_instr("stall5", 12'h105, 8'h05);
        redirect = 1'b1;
        redirect_target = 8'h1E;
        tick();
        redirect = 1'b0;
        bus.instr_ready = 1'b1;
        chk("redir flush", 32'(bus.instr_valid), 32'd0);
        chk("redir addr", 32'(bus.rom_address), 32'h1E);
        chk("redir running", 32'(running), 32'd1);
        tick();
        chk_instr("redir fetch", 12'h11E, 8'h1E);
        redirect = 1'b1;
        redirect_target = 8'hFE;
        tick();
        redirect = 1'b0;
        chk("wrap flush", 32'(bus.instr_valid), 32'd0);
        chk("wrap addr", 32'(bus.rom_address), 32'hFE);
        tick();
        chk_instr("wrap fe", 12'h1FE, 8'hFE);
        tick();
        chk_instr("wrap ff", 12'h1FF, 8'hFF);
        chk("wrap addr0", 32'(bus.rom_address), 32'h00);
        tick();
        chk_instr("wrap 00", 12'h000, 8'h00);
        tick();
        chk_instr("wrap 01", 12'h121, 8'h01);
        #3;
        rst = 1'b1;
        #1;
        chk("async valid", 32'(bus.instr_valid), 32'd0);
        chk("async addr", 32'(bus.rom_address), 32'd0);
        chk("async running", 32'(running), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        chk("post reset idle", 32'(bus.instr_valid), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_instr("restart", 12'h000, 8'h00);
        bus.instr_ready = 1'b0;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("ext halt running", 32'(running), 32'd0);
        chk_instr("ext halt hold", 12'h000, 8'h00);
        chk("ext halt addr", 32'(bus.rom_address), 32'h01);
        bus.instr_ready = 1'b1;
        tick();
        chk("ext halt drain", 32'(bus.instr_valid), 32'd0);
        chk("ext halt nofetch", 32'(bus.rom_address), 32'h01);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
